multicycle_sequencer: RTL and testbench
=======================================

// Module: multicycle_sequencer
// PURPOSE
//  Multi-cycle control FSM for the riscv-cpu core. Sequences each instruction through
//  FETCH -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK. Consumes control_signals_t from
//  instr_decode and gates instruction/data memory handshakes, IR load, register-file write
//  and PC update, so a single ALU and a single memory port are shared across cycles.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max consecutive wait cycles on a memory handshake; 0 = timeout disabled
//  COUNT_WIDTH     32   width of retired-instruction counter
// PORTS
//  clk            in   1            single clock; all state updates on posedge
//  rst_n          in   1            reset: synchronous, active-low
//  imem_req       out  1            instruction fetch request
//  imem_ready     in   1            instruction word valid this cycle
//  ir_load        out  1            latch instruction register
//  control        in   control_signals_t  decoded controls for current instr (from instr_decode)
//  branch_taken   in   1            branch comparator result, valid in WRITEBACK
//  dmem_req       out  1            data memory request
//  dmem_we        out  1            data memory write enable (store)
//  dmem_ready     in   1            data access complete this cycle
//  rf_write_en    out  1            register-file write strobe
//  pc_update      out  1            PC register load strobe
//  pc_select      out  1            0 = pc+4, 1 = branch/jump target
//  halt_req       in   1            request stop at next instruction boundary
//  halted         out  1            core idle in HALTED
//  timeout_error  out  1            sticky memory-handshake timeout flag
//  state          out  3            current FSM state (debug)
//  retired_count  out  COUNT_WIDTH  instructions retired
// BEHAVIOUR
//  - States/encodings: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, HALTED=5, ERROR=6.
//  - rst_n low at posedge: state<=FETCH, retired_count<=0, wait counter<=0, timeout_error<=0.
//    While rst_n low, all strobes/requests are forced 0 (imem_req, ir_load, dmem_req, dmem_we,
//    rf_write_en, pc_update, pc_select, halted). Reset mid-instruction abandons it; no write.
//  - FETCH: imem_req=1 held until imem_ready. In the ready cycle, ir_load=1 and next=DECODE.
//  - DECODE: one cycle, no strobes. Next=EXECUTE.
//  - EXECUTE: one cycle. If control.memory_read|memory_write, next=MEMORY; else WRITEBACK.
//  - MEMORY: dmem_req=1, dmem_we=control.memory_write, both held stable until dmem_ready.
//    Next=WRITEBACK on ready.
//  - WRITEBACK: one cycle. rf_write_en=control.register_write, pc_update=1,
//    pc_select=control.jump | (control.branch & branch_taken), retired_count+=1 (wraps to 0).
//    Next=HALTED if halt_req else FETCH.
//  - HALTED: halted=1, no requests. Leave to FETCH the cycle after halt_req samples 0.
//    halt_req outside WRITEBACK has no effect until the boundary.
//  - Timeout: wait counter increments each FETCH/MEMORY cycle with req=1 and ready=0.
//    It clears on ready or state change. When count reaches TIMEOUT_CYCLES (nonzero),
//    next=ERROR. In ERROR: timeout_error=1, all requests 0; exit only via reset.
//    A ready in the same cycle the limit is reached wins (normal advance).
//  - Latency: non-memory instr = 4 cycles with zero-wait imem; load/store = 5; each wait cycle +1.
//  - Outputs are decoded from the registered state (plus control/branch_taken/ready). No
//    output depends on halt_req combinationally.
// TESTING
//  1 Reset: rst_n=0 two cycles -> all strobes 0, retired_count=0; release -> imem_req=1, state=0.
//  2 ADDI with imem_ready=1 immediately -> states 0,1,2,4; rf_write_en=1 exactly once;
//    pc_select=0; retired_count=1 after 4 cycles.
//  3 SW with dmem_ready delayed 3 cycles -> dmem_req=1, dmem_we=1 for 4 cycles;
//    rf_write_en=0; 8 cycles total.
//  4 BEQ taken (branch=1, branch_taken=1) -> pc_update=1, pc_select=1 in WRITEBACK;
//    JAL -> pc_select=1, rf_write_en=1.
//  5 TIMEOUT_CYCLES=4, imem_ready held 0 -> ERROR after 4 wait cycles; timeout_error=1,
//    imem_req=0 until reset.
//  6 halt_req=1 during LW's WRITEBACK -> HALTED, halted=1; drop halt_req -> FETCH
//    next cycle. Assert rst_n=0 during MEMORY -> no rf write, state=FETCH.

Source files
------------

// File: rtl/multicycle_sequencer.sv
// Multi-cycle instruction sequencer: walks each instruction through fetch, decode, execute,
// optional memory and writeback, sharing one ALU and one memory port across cycles.
package multicycle_sequencer_pkg;
    typedef struct packed {
        logic register_write;
        logic memory_read;
        logic memory_write;
        logic branch;
        logic jump;
    } control_signals_t;
endpackage

module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   imem_req,
    input  logic                   imem_ready,
    output logic                   ir_load,
    input  control_signals_t       control,
    input  logic                   branch_taken,
    output logic                   dmem_req,
    output logic                   dmem_we,
    input  logic                   dmem_ready,
    output logic                   rf_write_en,
    output logic                   pc_update,
    output logic                   pc_select,
    input  logic                   halt_req,
    output logic                   halted,
    output logic                   timeout_error,
    output logic [2:0]             state,
    output logic [COUNT_WIDTH-1:0] retired_count
);
    localparam logic [2:0] S_FETCH     = 3'd0;
    localparam logic [2:0] S_DECODE    = 3'd1;
    localparam logic [2:0] S_EXECUTE   = 3'd2;
    localparam logic [2:0] S_MEMORY    = 3'd3;
    localparam logic [2:0] S_WRITEBACK = 3'd4;
    localparam logic [2:0] S_HALTED    = 3'd5;
    localparam logic [2:0] S_ERROR     = 3'd6;

    // The counter only needs to reach TIMEOUT_CYCLES-1: the wait that would make it
    // TIMEOUT_CYCLES is the one that diverts to ERROR.
    localparam int WW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    logic [2:0]    next_state;
    logic [WW-1:0] wait_cnt;
    logic          waiting;
    logic          limit;

    assign waiting = (state == S_FETCH  && !imem_ready) ||
                     (state == S_MEMORY && !dmem_ready);
    assign limit   = (TIMEOUT_CYCLES != 0) && (wait_cnt == WW'(LIM));

    always_comb begin
        next_state = state;
        case (state)
            S_FETCH:     if (imem_ready) next_state = S_DECODE;
                         else if (limit) next_state = S_ERROR;
            S_DECODE:    next_state = S_EXECUTE;
            S_EXECUTE:   next_state = (control.memory_read || control.memory_write) ?
                                      S_MEMORY : S_WRITEBACK;
            S_MEMORY:    if (dmem_ready) next_state = S_WRITEBACK;
                         else if (limit) next_state = S_ERROR;
            S_WRITEBACK: next_state = halt_req ? S_HALTED : S_FETCH;
            S_HALTED:    next_state = halt_req ? S_HALTED : S_FETCH;
            S_ERROR:     next_state = S_ERROR;
            default:     next_state = S_ERROR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_FETCH;
            retired_count <= '0;
            wait_cnt      <= '0;
        end else begin
            state <= next_state;
            if (state == S_WRITEBACK)
                retired_count <= retired_count + COUNT_WIDTH'(1);
            if (next_state != state || !waiting)
                wait_cnt <= '0;
            else if (TIMEOUT_CYCLES != 0)
                wait_cnt <= wait_cnt + WW'(1);
        end
    end

    // Strobes decode from the registered state; reset masks them all.
    always_comb begin
        imem_req      = 1'b0;
        ir_load       = 1'b0;
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        rf_write_en   = 1'b0;
        pc_update     = 1'b0;
        pc_select     = 1'b0;
        halted        = 1'b0;
        timeout_error = 1'b0;
        if (rst_n) begin
            case (state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    ir_load  = imem_ready;
                end
                S_MEMORY: begin
                    dmem_req = 1'b1;
                    dmem_we  = control.memory_write;
                end
                S_WRITEBACK: begin
                    rf_write_en = control.register_write;
                    pc_update   = 1'b1;
                    pc_select   = control.jump | (control.branch & branch_taken);
                end
                S_HALTED: halted        = 1'b1;
                S_ERROR:  timeout_error = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: per-instruction timelines derived from the latency rules,
// a directed table, randomized instruction streams, and halt/reset/timeout corner sequences.
module tb_multicycle_sequencer;
    import multicycle_sequencer_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             imem_req, imem_ready = 1'b0, ir_load;
    control_signals_t control = '0;
    logic             branch_taken = 1'b0;
    logic             dmem_req, dmem_we, dmem_ready = 1'b0;
    logic             rf_write_en, pc_update, pc_select;
    logic             halt_req = 1'b0, halted, timeout_error;
    logic [2:0]       state;
    logic [2:0]       retired_count;

    multicycle_sequencer #(.TIMEOUT_CYCLES(4), .COUNT_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_ready(imem_ready),
        .ir_load(ir_load), .control(control), .branch_taken(branch_taken),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_write_en(rf_write_en), .pc_update(pc_update), .pc_select(pc_select),
        .halt_req(halt_req), .halted(halted), .timeout_error(timeout_error),
        .state(state), .retired_count(retired_count)
    );

    always #5 clk = ~clk;

    // {imem_req, ir_load, dmem_req, dmem_we, rf_write_en, pc_update, pc_select, halted, timeout_error}
    logic [8:0] outs;
    assign outs = {imem_req, ir_load, dmem_req, dmem_we, rf_write_en,
                   pc_update, pc_select, halted, timeout_error};

    int n_pass = 0;
    int n_total = 0;
    int exp_ret = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    endtask

    // One planned cycle: expected state, inputs to present, expected outputs.
    typedef struct packed {
        logic [2:0] st;
        logic       ir, dr, hr;
        logic [8:0] o;
    } cyc_t;
    cyc_t plan[$];

    // Timeline straight from the latency rules: iw fetch waits, fetch, decode, execute,
    // dw+1 memory cycles for loads/stores, writeback, then hc cycles parked in HALTED.
    task automatic build(input control_signals_t c, input logic bt, input int iw, input int dw,
                         input int hc);
        logic mem;
        mem = c.memory_read | c.memory_write;
        plan.delete();
        for (int i = 0; i < iw; i++) plan.push_back({3'd0, 3'b000, 9'b1_0000_0000});
        plan.push_back({3'd0, 3'b100, 9'b1_1000_0000});
        plan.push_back({3'd1, 3'b000, 9'b0});
        plan.push_back({3'd2, 3'b000, 9'b0});
        if (mem) begin
            for (int j = 0; j < dw; j++)
                plan.push_back({3'd3, 3'b000, 2'b00, 1'b1, c.memory_write, 5'b0});
            plan.push_back({3'd3, 3'b010, 2'b00, 1'b1, c.memory_write, 5'b0});
        end
        plan.push_back({3'd4, 2'b00, hc > 0, 4'b0, c.register_write, 1'b1,
                        c.jump | (c.branch & bt), 2'b00});
        for (int h = 0; h < hc; h++)
            plan.push_back({3'd5, 2'b00, h < hc - 1, 9'b0_0000_0010});
    endtask

    task automatic run_instr(input control_signals_t c, input logic bt, input int iw,
                             input int dw, input int hc,
                             output int obs_cyc, output int obs_rfw, output logic obs_pcs);
        bit seen_wb = 0;
        build(c, bt, iw, dw, hc);
        control = c;
        obs_cyc = 0; obs_rfw = 0; obs_pcs = 1'b0;
        foreach (plan[k]) begin
            @(negedge clk);
            imem_ready   = plan[k].ir;
            dmem_ready   = plan[k].dr;
            halt_req     = (plan[k].st == 3'd4 || plan[k].st == 3'd5) ? plan[k].hr : 1'($urandom);
            branch_taken = (plan[k].st == 3'd4) ? bt : 1'($urandom);
            #1;
            chk("state", 32'(state), 32'(plan[k].st));
            chk("outputs", 32'(outs), 32'(plan[k].o));
            if (!seen_wb) obs_cyc++;
            if (state == 3'd4) begin
                seen_wb = 1;
                chk("retired_count", 32'(retired_count), 32'(exp_ret));
            end
            if (rf_write_en) obs_rfw++;
            if (pc_update) obs_pcs = pc_select;
        end
        exp_ret = (exp_ret + 1) % 8;
    endtask

    typedef struct {
        string            nm;
        control_signals_t c;
        logic             bt;
        int               iw, dw;
        int               cyc, rfw;
        logic             pcs;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int oc, orf;
        logic op;
        control_signals_t rc;

        //              name          {rw,mr,mw,b,j} bt iw dw cyc rfw pcs
        tbl[0] = '{"addi",         5'b10000, 1'b0, 0, 0, 4, 1, 1'b0};
        tbl[1] = '{"sw_wait3",     5'b00100, 1'b0, 0, 3, 8, 0, 1'b0};
        tbl[2] = '{"beq_taken",    5'b00010, 1'b1, 0, 0, 4, 0, 1'b1};
        tbl[3] = '{"beq_not",      5'b00010, 1'b0, 0, 0, 4, 0, 1'b0};
        tbl[4] = '{"jal",          5'b10001, 1'b0, 0, 0, 4, 1, 1'b1};
        tbl[5] = '{"lw_fetch3",    5'b11000, 1'b0, 3, 0, 8, 1, 1'b0};
        tbl[6] = '{"lw_2_2",       5'b11000, 1'b1, 2, 2, 9, 1, 1'b0};
        tbl[7] = '{"jal_bnt",      5'b10011, 1'b0, 1, 0, 5, 1, 1'b1};

        // Reset held two cycles with busy-looking inputs: every strobe stays low.
        imem_ready = 1'b1; dmem_ready = 1'b1; halt_req = 1'b1; branch_taken = 1'b1;
        control = 5'b11111;
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset_outs", 32'(outs), 32'h0);
            chk("reset_state", 32'(state), 32'h0);
            chk("reset_retired", 32'(retired_count), 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1; imem_ready = 1'b0; halt_req = 1'b0;
        #1;
        chk("release_imem_req", 32'(imem_req), 32'h1);
        chk("release_state", 32'(state), 32'h0);

        foreach (tbl[i]) begin
            run_instr(tbl[i].c, tbl[i].bt, tbl[i].iw, tbl[i].dw, 0, oc, orf, op);
            chk({tbl[i].nm, "_cycles"}, 32'(oc), 32'(tbl[i].cyc));
            chk({tbl[i].nm, "_rf_writes"}, 32'(orf), 32'(tbl[i].rfw));
            chk({tbl[i].nm, "_pc_select"}, 32'(op), 32'(tbl[i].pcs));
        end

        // Random instruction stream; retired_count wraps through 3 bits several times.
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 4))
                0: rc = {1'($urandom), 4'b0000};
                1: rc = 5'b11000;
                2: rc = 5'b00100;
                3: rc = 5'b00010;
                default: rc = 5'b10001;
            endcase
            run_instr(rc, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0, oc, orf, op);
        end

        // Halt requested in a load's writeback, held, then dropped.
        run_instr(5'b11000, 1'b0, 0, 1, 3, oc, orf, op);
        chk("halt_lw_rf_writes", 32'(orf), 32'h1);

        // Reset asserted while a load waits in MEMORY: the load is abandoned.
        control = 5'b11000;
        @(negedge clk); imem_ready = 1'b1; halt_req = 1'b0; #1;
        chk("rst_mem_fetch", 32'(state), 32'h0);
        @(negedge clk); imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk); dmem_ready = 1'b0; #1;
        chk("rst_mem_in_memory", 32'({state, dmem_req}), 32'({3'd3, 1'b1}));
        @(negedge clk); rst_n = 1'b0; #1;
        chk("rst_mem_strobes", 32'(outs), 32'h0);
        @(negedge clk); rst_n = 1'b1; dmem_ready = 1'b1; #1;
        chk("rst_mem_state", 32'(state), 32'h0);
        chk("rst_mem_retired", 32'(retired_count), 32'h0);
        exp_ret = 0;

        // Timeout: the release cycle is the first of four waits, the fifth cycle is ERROR.
        for (int w = 0; w < 3; w++) begin
            @(negedge clk); imem_ready = 1'b0; #1;
            chk("timeout_waiting", 32'({state, imem_req}), 32'({3'd0, 1'b1}));
        end
        for (int e = 0; e < 3; e++) begin
            @(negedge clk); imem_ready = 1'(e != 0); #1;
            chk("timeout_error_state", 32'(state), 32'h6);
            chk("timeout_error_outs", 32'(outs), 32'h1);
        end
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1; imem_ready = 1'b1; #1;
        chk("after_error_reset", 32'({state, timeout_error, imem_req, ir_load}),
            32'({3'd0, 1'b0, 1'b1, 1'b1}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
